// File: rtl/cpu_bus_gen_if.sv
// cpu_bus_gen_if
// Bundles the CPU-side request/response signals and the 32-bit bus-side
// signals handled by the cpu_bus_gen bridge.
//   master modport : the bridge (drives bus_*, answers cpu_*)
//   slave  modport : the environment (CPU plus bus target)
// Signals:
//   bus_stb/bus_we/bus_ben/bus_lock/bus_addr/bus_dout : bridge -> bus
//   bus_din/bus_ack/bus_irq                           : bus -> bridge
//   cpu_stb/cpu_we/cpu_ben/cpu_sx/cpu_addr/cpu_dout   : CPU -> bridge
//   cpu_din/cpu_ack/cpu_err/cpu_irq                   : bridge -> CPU
interface cpu_bus_gen_if #(
    parameter int AW    = 24,
    parameter int IRQ_W = 16
) ();
    logic             bus_stb;
    logic             bus_we;
    logic [3:0]       bus_ben;
    logic             bus_lock;
    logic [AW-3:0]    bus_addr;
    logic [31:0]      bus_dout;
    logic [31:0]      bus_din;
    logic             bus_ack;
    logic [IRQ_W-1:0] bus_irq;

    logic             cpu_stb;
    logic             cpu_we;
    logic [1:0]       cpu_ben;
    logic             cpu_sx;
    logic [AW-1:0]    cpu_addr;
    logic [31:0]      cpu_dout;
    logic [31:0]      cpu_din;
    logic             cpu_ack;
    logic             cpu_err;
    logic [IRQ_W-1:0] cpu_irq;

    modport master (
        output bus_stb, bus_we, bus_ben, bus_lock, bus_addr, bus_dout,
        input  bus_din, bus_ack, bus_irq,
        input  cpu_stb, cpu_we, cpu_ben, cpu_sx, cpu_addr, cpu_dout,
        output cpu_din, cpu_ack, cpu_err, cpu_irq
    );

    modport slave (
        input  bus_stb, bus_we, bus_ben, bus_lock, bus_addr, bus_dout,
        output bus_din, bus_ack, bus_irq,
        output cpu_stb, cpu_we, cpu_ben, cpu_sx, cpu_addr, cpu_dout,
        input  cpu_din, cpu_ack, cpu_err, cpu_irq
    );
endinterface

// File: rtl/cpu_bus_gen.sv
// cpu_bus_gen
// Bridges a byte/half/word CPU access port onto a 32-bit word bus with
// byte-lane enables. Sub-word writes are either issued as one strobed bus
// write (STROBE_MODE=1) or as a locked read-modify-write pair (STROBE_MODE=0).
// A bus cycle left unacknowledged for TIMEOUT cycles is aborted with cpu_err.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : cpu_bus_gen_if master modport (CPU side and bus side)
module cpu_bus_gen #(
    parameter int AW          = 24,
    parameter int STROBE_MODE = 0,
    parameter int TIMEOUT     = 256,
    parameter int IRQ_W       = 16
) (
    input logic           clk,
    input logic           rst_n,
    cpu_bus_gen_if.master bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [0:0] {IDLE, RMW_WR} StateT;

    StateT            r_state;
    StateT            w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_wbuf;

    logic             w_isByte;
    logic             w_isHalf;
    logic             w_isSub;
    logic [3:0]       w_laneMask;
    logic [31:0]      w_laneBits;
    logic [31:0]      w_replData;
    logic [31:0]      w_mergeData;
    logic [7:0]       w_byteSel;
    logic [15:0]      w_halfSel;
    logic [31:0]      w_rdData;
    logic [IRQ_W-1:0] w_irq;

    logic             w_busStb;
    logic             w_busWe;
    logic [3:0]       w_busBen;
    logic             w_busLock;
    logic [31:0]      w_busDout;
    logic             w_cpuAck;
    logic             w_cpuErr;
    logic             w_rmwRead;
    logic             w_expire;

    // Decode access size and lane from the CPU request, and prepare the
    // lane-replicated write data plus the merged word for the RMW write phase.
    always_comb begin
        w_isByte   = bus.cpu_ben[1];
        w_isHalf   = (bus.cpu_ben == 2'b01);
        w_isSub    = w_isByte | w_isHalf;
        if (w_isByte) begin
            w_laneMask = 4'b0001 << bus.cpu_addr[1:0];
        end else if (w_isHalf) begin
            w_laneMask = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            w_laneMask = 4'b1111;
        end
        w_laneBits  = {{8{w_laneMask[3]}}, {8{w_laneMask[2]}},
                       {8{w_laneMask[1]}}, {8{w_laneMask[0]}}};
        w_replData  = w_isByte ? {4{bus.cpu_dout[7:0]}} : {2{bus.cpu_dout[15:0]}};
        w_mergeData = (bus.bus_din & ~w_laneBits) | (w_replData & w_laneBits);
    end

    // Pick the addressed lane out of the bus word and extend it to 32 bits.
    always_comb begin
        case (bus.cpu_addr[1:0])
            2'd0:    w_byteSel = bus.bus_din[7:0];
            2'd1:    w_byteSel = bus.bus_din[15:8];
            2'd2:    w_byteSel = bus.bus_din[23:16];
            default: w_byteSel = bus.bus_din[31:24];
        endcase
        w_halfSel = bus.cpu_addr[1] ? bus.bus_din[31:16] : bus.bus_din[15:0];
        if (w_isByte) begin
            w_rdData = {{24{bus.cpu_sx & w_byteSel[7]}}, w_byteSel};
        end else if (w_isHalf) begin
            w_rdData = {{16{bus.cpu_sx & w_halfSel[15]}}, w_halfSel};
        end else begin
            w_rdData = bus.bus_din;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: the RMW read only advances on a real ack, so an expiry
    // during the read leaves the state in IDLE with wbuf untouched.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_rmwRead && bus.bus_ack) begin
                    w_nextState = RMW_WR;
                end
            end
            RMW_WR: begin
                if (bus.bus_ack || w_expire) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs: the CPU ack follows bus_ack combinationally except during the
    // RMW read phase. Expiry forces an erroring ack unless bus_ack arrives in
    // the same cycle. Reset masks every strobe and handshake output.
    always_comb begin
        w_busStb  = 1'b0;
        w_busWe   = 1'b0;
        w_busBen  = 4'b0000;
        w_busLock = 1'b0;
        w_busDout = bus.cpu_dout;
        w_cpuAck  = 1'b0;
        w_cpuErr  = 1'b0;
        w_rmwRead = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cpu_stb) begin
                    w_busStb = 1'b1;
                    if (!bus.cpu_we) begin
                        w_busBen = w_laneMask;
                        w_cpuAck = bus.bus_ack;
                    end else if (!w_isSub) begin
                        w_busWe  = 1'b1;
                        w_busBen = 4'b1111;
                        w_cpuAck = bus.bus_ack;
                    end else if (STROBE_MODE != 0) begin
                        w_busWe   = 1'b1;
                        w_busBen  = w_laneMask;
                        w_busDout = w_replData;
                        w_cpuAck  = bus.bus_ack;
                    end else begin
                        w_busBen  = 4'b1111;
                        w_busLock = 1'b1;
                        w_rmwRead = 1'b1;
                    end
                end
            end
            RMW_WR: begin
                w_busStb  = 1'b1;
                w_busWe   = 1'b1;
                w_busBen  = 4'b1111;
                w_busLock = 1'b1;
                w_busDout = r_wbuf;
                w_cpuAck  = bus.bus_ack;
            end
            default: begin
                w_busStb = 1'b0;
            end
        endcase
        w_expire = (TIMEOUT > 0) && w_busStb && !bus.bus_ack && (r_cnt == LAST);
        if (w_expire) begin
            w_cpuAck = 1'b1;
            w_cpuErr = 1'b1;
        end
        if (!rst_n) begin
            w_busStb  = 1'b0;
            w_busWe   = 1'b0;
            w_busBen  = 4'b0000;
            w_busLock = 1'b0;
            w_cpuAck  = 1'b0;
            w_cpuErr  = 1'b0;
        end
    end

    // Timeout counter and RMW write buffer. The counter restarts whenever the
    // bus is idle or acknowledges, so each bus phase gets its own budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wbuf <= '0;
        end else begin
            if (w_rmwRead && bus.bus_ack) begin
                r_wbuf <= w_mergeData;
            end
            if ((TIMEOUT == 0) || !w_busStb || bus.bus_ack || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign w_irq        = bus.bus_irq;
    assign bus.cpu_irq  = w_irq;
    assign bus.cpu_din  = w_rdData;
    assign bus.cpu_ack  = w_cpuAck;
    assign bus.cpu_err  = w_cpuErr;
    assign bus.bus_stb  = w_busStb;
    assign bus.bus_we   = w_busWe;
    assign bus.bus_ben  = w_busBen;
    assign bus.bus_lock = w_busLock;
    assign bus.bus_addr = bus.cpu_addr[AW-1:2];
    assign bus.bus_dout = w_busDout;

endmodule

// File: tb/tb_cpu_bus_gen.sv
// tb_cpu_bus_gen
// Drives two bridge instances: u0 (read-modify-write sub-word writes,
// TIMEOUT=4) and u1 (strobed sub-word writes, timeout disabled). Expected
// completions are queued when a request is driven and scored when the
// bridge acknowledges it.
module tb_cpu_bus_gen;
    localparam int AW    = 24;
    localparam int IRQ_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    cpu_bus_gen_if #(.AW(AW), .IRQ_W(IRQ_W)) ifA ();
    cpu_bus_gen_if #(.AW(AW), .IRQ_W(IRQ_W)) ifB ();

    cpu_bus_gen #(.AW(AW), .STROBE_MODE(0), .TIMEOUT(4), .IRQ_W(IRQ_W)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(ifA)
    );
    cpu_bus_gen #(.AW(AW), .STROBE_MODE(1), .TIMEOUT(0), .IRQ_W(IRQ_W)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(ifB)
    );

    typedef struct {
        logic          stb;
        logic          we;
        logic [3:0]    ben;
        logic          lock;
        logic [AW-3:0] addr;
        logic [31:0]   dout;
        logic [31:0]   din;
        logic          ack;
        logic          err;
    } ObsT;

    typedef struct {
        string         name;
        bit            sel;
        logic          we;
        logic [1:0]    ben;
        logic          sx;
        logic [AW-1:0] addr;
        logic [31:0]   dout;
        logic [31:0]   busDin;
        logic [3:0]    expBen;
        logic          expWe;
        logic          expLock;
        logic          expErr;
        logic [31:0]   expDout;
        bit            chkDout;
        logic [31:0]   expDin;
        bit            chkDin;
    } VecT;

    typedef struct {
        string         name;
        bit            sel;
        logic [3:0]    ben;
        logic          we;
        logic          lock;
        logic          err;
        logic [AW-3:0] addr;
        logic [31:0]   dout;
        bit            chkDout;
        logic [31:0]   din;
        bit            chkDin;
    } ExpT;

    ExpT sbQueue[$];
    int  checks = 0;
    int  errors = 0;

    function automatic ObsT observe(input bit sel);
        ObsT o;
        if (sel) begin
            o.stb = ifB.bus_stb;  o.we = ifB.bus_we;     o.ben = ifB.bus_ben;
            o.lock = ifB.bus_lock; o.addr = ifB.bus_addr; o.dout = ifB.bus_dout;
            o.din = ifB.cpu_din;  o.ack = ifB.cpu_ack;   o.err = ifB.cpu_err;
        end else begin
            o.stb = ifA.bus_stb;  o.we = ifA.bus_we;     o.ben = ifA.bus_ben;
            o.lock = ifA.bus_lock; o.addr = ifA.bus_addr; o.dout = ifA.bus_dout;
            o.din = ifA.cpu_din;  o.ack = ifA.cpu_ack;   o.err = ifA.cpu_err;
        end
        return o;
    endfunction

    function automatic VecT mkVec(input string name, input bit sel, input logic we,
                                  input logic [1:0] ben, input logic sx,
                                  input logic [AW-1:0] addr, input logic [31:0] dout,
                                  input logic [31:0] busDin, input logic [3:0] expBen,
                                  input logic [31:0] expData);
        VecT v;
        v.name = name; v.sel = sel; v.we = we; v.ben = ben; v.sx = sx;
        v.addr = addr; v.dout = dout; v.busDin = busDin; v.expBen = expBen;
        v.expWe = we; v.expLock = 1'b0; v.expErr = 1'b0;
        v.expDout = expData; v.chkDout = we;
        v.expDin = expData;  v.chkDin = !we;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic checkObs(input string name, input ObsT o, input logic stb, input logic we,
                            input logic [3:0] ben, input logic lock, input logic ack,
                            input logic err);
        checkOutput({name, ".stb"}, o.stb, stb);
        checkOutput({name, ".we"}, o.we, we);
        checkOutput({name, ".ben"}, o.ben, ben);
        checkOutput({name, ".lock"}, o.lock, lock);
        checkOutput({name, ".ack"}, o.ack, ack);
        checkOutput({name, ".err"}, o.err, err);
    endtask

    task automatic driveCpu(input bit sel, input logic stb, input logic we, input logic [1:0] ben,
                            input logic sx, input logic [AW-1:0] addr, input logic [31:0] dout);
        if (sel) begin
            ifB.cpu_stb = stb; ifB.cpu_we = we; ifB.cpu_ben = ben;
            ifB.cpu_sx = sx;   ifB.cpu_addr = addr; ifB.cpu_dout = dout;
        end else begin
            ifA.cpu_stb = stb; ifA.cpu_we = we; ifA.cpu_ben = ben;
            ifA.cpu_sx = sx;   ifA.cpu_addr = addr; ifA.cpu_dout = dout;
        end
    endtask

    task automatic driveBus(input bit sel, input logic ack, input logic [31:0] din);
        if (sel) begin
            ifB.bus_ack = ack; ifB.bus_din = din;
        end else begin
            ifA.bus_ack = ack; ifA.bus_din = din;
        end
    endtask

    task automatic idleCpu(input bit sel);
        driveCpu(sel, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        driveBus(sel, 1'b0, '0);
    endtask

    // Drive one CPU request and queue what its completion must look like.
    task automatic applyStimulus(input VecT v, input bit ackNow);
        ExpT e;
        driveBus(v.sel, ackNow, v.busDin);
        driveCpu(v.sel, 1'b1, v.we, v.ben, v.sx, v.addr, v.dout);
        e.name = v.name; e.sel = v.sel; e.ben = v.expBen; e.we = v.expWe;
        e.lock = v.expLock; e.err = v.expErr; e.addr = v.addr[AW-1:2];
        e.dout = v.expDout; e.chkDout = v.chkDout;
        e.din = v.expDin;   e.chkDin = v.chkDin;
        sbQueue.push_back(e);
    endtask

    // Wait (bounded) for cpu_ack on one bridge and score it against the queue.
    task automatic scoreNext(input bit sel, input int limit, output int cycles);
        ObsT o;
        ExpT e;
        bit  done;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
            o = observe(sel);
            if (o.ack === 1'b1) begin
                done = 1'b1;
                if (sbQueue.size() == 0) begin
                    checkOutput("sb.unexpectedAck", 32'd1, 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput({e.name, ".stb"}, o.stb, 1'b1);
                    checkOutput({e.name, ".we"}, o.we, e.we);
                    checkOutput({e.name, ".ben"}, o.ben, e.ben);
                    checkOutput({e.name, ".lock"}, o.lock, e.lock);
                    checkOutput({e.name, ".err"}, o.err, e.err);
                    checkOutput({e.name, ".addr"}, 32'(o.addr), 32'(e.addr));
                    if (e.chkDout) checkOutput({e.name, ".dout"}, o.dout, e.dout);
                    if (e.chkDin)  checkOutput({e.name, ".din"}, o.din, e.din);
                end
            end
        end
        if (!done) begin
            checkOutput("sb.ackTimeout", cycles, limit + 1);
            if (sbQueue.size() != 0) e = sbQueue.pop_front();
        end
    endtask

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Stimulus: reset, vector table, then multi-cycle corner sequences.
    initial begin
        VecT vecs[13];
        VecT v;
        ObsT o;
        int  cyc;
        int  acks;
        int  errs;

        vecs[0]  = mkVec("rdB3sx",  0, 0, 2'b10, 1, 24'h000003, 32'h0, 32'h80FF1234, 4'b1000, 32'hFFFFFF80);
        vecs[1]  = mkVec("rdB3zx",  0, 0, 2'b11, 0, 24'h000003, 32'h0, 32'h80FF1234, 4'b1000, 32'h00000080);
        vecs[2]  = mkVec("rdB1sx",  0, 0, 2'b10, 1, 24'h000001, 32'h0, 32'h80FF1234, 4'b0010, 32'h00000012);
        vecs[3]  = mkVec("rdH2sx",  0, 0, 2'b01, 1, 24'h000002, 32'h0, 32'h80FF1234, 4'b1100, 32'hFFFF80FF);
        vecs[4]  = mkVec("rdH3zx",  0, 0, 2'b01, 0, 24'h000003, 32'h0, 32'h80FF1234, 4'b1100, 32'h000080FF);
        vecs[5]  = mkVec("rdH0sx",  0, 0, 2'b01, 1, 24'h000000, 32'h0, 32'h80FF1234, 4'b0011, 32'h00001234);
        vecs[6]  = mkVec("rdWord",  0, 0, 2'b00, 1, 24'h000123, 32'h0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        vecs[7]  = mkVec("wrWord",  0, 1, 2'b00, 0, 24'h000010, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D);
        vecs[8]  = mkVec("wrHstb",  1, 1, 2'b01, 0, 24'h000002, 32'h00005678, 32'h0, 4'b1100, 32'h56785678);
        vecs[9]  = mkVec("wrBstb",  1, 1, 2'b10, 0, 24'h000001, 32'h000000AB, 32'h0, 4'b0010, 32'hABABABAB);
        vecs[10] = mkVec("rdB2stb", 1, 0, 2'b10, 1, 24'h000002, 32'h0, 32'h007F0000, 4'b0100, 32'h0000007F);
        vecs[11] = mkVec("wrWstb",  1, 1, 2'b00, 0, 24'hFFFFFC, 32'h89ABCDEF, 32'h0, 4'b1111, 32'h89ABCDEF);
        vecs[12] = mkVec("rdH6stb", 1, 0, 2'b01, 0, 24'h000006, 32'h0, 32'hFFFF0000, 4'b1100, 32'h0000FFFF);

        ifA.bus_irq = '0;
        ifB.bus_irq = '0;
        idleCpu(0);
        idleCpu(1);

        // Reset with active requests and acks: everything must stay quiet.
        driveCpu(0, 1'b1, 1'b1, 2'b00, 1'b0, 24'h000100, 32'h12345678);
        driveCpu(1, 1'b1, 1'b1, 2'b00, 1'b0, 24'h000100, 32'h12345678);
        driveBus(0, 1'b1, 32'h0);
        driveBus(1, 1'b1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkObs("rstA", observe(0), 0, 0, 4'b0000, 0, 0, 0);
        checkObs("rstB", observe(1), 0, 0, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        idleCpu(0);
        idleCpu(1);
        rst_n = 1'b1;
        @(negedge clk);
        checkObs("idleA", observe(0), 0, 0, 4'b0000, 0, 0, 0);
        checkObs("idleB", observe(1), 0, 0, 4'b0000, 0, 0, 0);

        ifA.bus_irq = 16'hA5C3;
        ifB.bus_irq = 16'h0001;
        #1;
        checkOutput("irqA1", ifA.cpu_irq, 16'hA5C3);
        checkOutput("irqB1", ifB.cpu_irq, 16'h0001);
        ifA.bus_irq = 16'h8000;
        ifB.bus_irq = 16'hFFFF;
        #1;
        checkOutput("irqA2", ifA.cpu_irq, 16'h8000);
        checkOutput("irqB2", ifB.cpu_irq, 16'hFFFF);

        // Single-cycle accesses from the vector table.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i], 1'b1);
            scoreNext(vecs[i].sel, 4, cyc);
            checkOutput({vecs[i].name, ".lat"}, cyc, 1);
            @(posedge clk);
            #1;
            idleCpu(vecs[i].sel);
        end

        // Byte read-modify-write, read acked at once.
        @(posedge clk);
        #1;
        v = mkVec("rmwB", 0, 1, 2'b10, 0, 24'h000101, 32'h000000AB, 32'h11223344, 4'b1111, 32'h1122AB44);
        v.expLock = 1'b1;
        applyStimulus(v, 1'b1);
        @(negedge clk);
        o = observe(0);
        checkObs("rmwB.rd", o, 1, 0, 4'b1111, 1, 0, 0);
        @(posedge clk);
        #1;
        driveBus(0, 1'b1, 32'h0);
        scoreNext(0, 4, cyc);
        checkOutput("rmwB.lat", cyc, 1);
        @(posedge clk);
        #1;
        idleCpu(0);
        @(negedge clk);
        checkObs("rmwB.after", observe(0), 0, 0, 4'b0000, 0, 0, 0);

        // Half-word read-modify-write with a slow read.
        @(posedge clk);
        #1;
        v = mkVec("rmwH", 0, 1, 2'b01, 0, 24'h000202, 32'h1234BEEF, 32'h11223344, 4'b1111, 32'hBEEF3344);
        v.expLock = 1'b1;
        applyStimulus(v, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkObs("rmwH.wait", observe(0), 1, 0, 4'b1111, 1, 0, 0);
            @(posedge clk);
            #1;
        end
        driveBus(0, 1'b1, 32'h11223344);
        scoreNext(0, 4, cyc);
        checkOutput("rmwH.lat", cyc, 2);
        @(posedge clk);
        #1;
        idleCpu(0);

        // Word read never acked: abort in the fourth strobe cycle.
        @(posedge clk);
        #1;
        v = mkVec("tmo", 0, 0, 2'b00, 0, 24'h000040, 32'h0, 32'h0, 4'b1111, 32'h0);
        v.expErr = 1'b1;
        v.chkDin = 1'b0;
        applyStimulus(v, 1'b0);
        scoreNext(0, 8, cyc);
        checkOutput("tmo.lat", cyc, 4);
        @(posedge clk);
        #1;
        idleCpu(0);
        @(negedge clk);
        checkObs("tmo.after", observe(0), 0, 0, 4'b0000, 0, 0, 0);

        // Ack arriving exactly in the expiry cycle completes normally.
        @(posedge clk);
        #1;
        v = mkVec("tmoAck", 0, 0, 2'b00, 0, 24'h000044, 32'h0, 32'h13572468, 4'b1111, 32'h13572468);
        applyStimulus(v, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("tmoAck.early", observe(0).ack, 1'b0);
            @(posedge clk);
            #1;
        end
        driveBus(0, 1'b1, 32'h13572468);
        scoreNext(0, 2, cyc);
        @(posedge clk);
        #1;
        idleCpu(0);

        // Reset while in the RMW write phase abandons the write.
        @(posedge clk);
        #1;
        driveCpu(0, 1'b1, 1'b1, 2'b10, 1'b0, 24'h000000, 32'h00000055);
        driveBus(0, 1'b1, 32'h0);
        @(negedge clk);
        checkObs("rstRmw.rd", observe(0), 1, 0, 4'b1111, 1, 0, 0);
        @(posedge clk);
        #1;
        driveBus(0, 1'b0, 32'h0);
        @(negedge clk);
        checkObs("rstRmw.wr", observe(0), 1, 1, 4'b1111, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        driveBus(0, 1'b1, 32'h0);
        @(negedge clk);
        checkObs("rstRmw.inRst", observe(0), 0, 0, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCpu(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkObs("rstRmw.post", observe(0), 0, 0, 4'b0000, 0, 0, 0);
        end

        // Timeout disabled: no abort within 1000 unacknowledged cycles.
        @(posedge clk);
        #1;
        v = mkVec("noTmo", 1, 0, 2'b00, 0, 24'h000080, 32'h0, 32'h0F0F0F0F, 4'b1111, 32'h0F0F0F0F);
        applyStimulus(v, 1'b0);
        acks = 0;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ifB.cpu_ack !== 1'b0) acks++;
            if (ifB.cpu_err !== 1'b0) errs++;
        end
        checkOutput("noTmo.acks", acks, 0);
        checkOutput("noTmo.errs", errs, 0);
        @(posedge clk);
        #1;
        driveBus(1, 1'b1, 32'h0F0F0F0F);
        scoreNext(1, 2, cyc);
        @(posedge clk);
        #1;
        idleCpu(1);

        checkOutput("sb.empty", sbQueue.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
